// File: rtl/aes_sbox_array.sv
// rtl/aes_sbox_array.sv - pipelined forward/inverse AES S-box array with valid/ready handshake
// Each lane computes the S-box from GF(2^8) inversion plus the affine map; no lookup ROM.

module aes_sbox_lane (
    input  logic       inv_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

    // Multiplication modulo the AES polynomial x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ t;
            end
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // a^254 == a^-1 for nonzero a, and maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = gf_mul(a, a);
        r = p;
        for (int k = 2; k < 8; k++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] a);
        return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]} ^ {a[3:0], a[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] a);
        return {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    endfunction

    logic [7:0] pre;
    logic [7:0] mid;

    // One shared inverter per lane: the direction only moves the affine step.
    always_comb begin
        pre    = inv_i ? inv_affine(data_i) : data_i;
        mid    = gf_inv(pre);
        data_o = inv_i ? mid : affine(mid);
    end

endmodule

module aes_sbox_array #(
    parameter int LANES = 4,
    parameter int PIPE  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_mode,
    input  logic [8*LANES-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_mode,
    output logic [8*LANES-1:0] out_data,
    output logic               busy
);

    localparam int W = 8 * LANES;

    logic         sub_v;
    logic         sub_mode;
    logic [W-1:0] sub_data;
    logic [W-1:0] sub_res;
    logic         stage_busy;
    logic         adv_last;

    logic         out_v_q, out_v_d;
    logic         out_mode_q, out_mode_d;
    logic [W-1:0] out_data_q, out_data_d;

    assign adv_last = !out_v_q || out_ready;

    generate
        if (PIPE == 2) begin : g_pipe2
            logic         s0_v_q, s0_v_d;
            logic         s0_mode_q, s0_mode_d;
            logic [W-1:0] s0_data_q, s0_data_d;
            logic         adv0;

            always_comb begin
                adv0      = !s0_v_q || adv_last;
                s0_v_d    = s0_v_q;
                s0_mode_d = s0_mode_q;
                s0_data_d = s0_data_q;
                if (adv0) begin
                    s0_v_d = in_valid;
                    // Idle input leaves the payload registers untouched.
                    if (in_valid) begin
                        s0_mode_d = in_mode;
                        s0_data_d = in_data;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    s0_v_q    <= 1'b0;
                    s0_mode_q <= 1'b0;
                    s0_data_q <= '0;
                end else begin
                    s0_v_q    <= s0_v_d;
                    s0_mode_q <= s0_mode_d;
                    s0_data_q <= s0_data_d;
                end
            end

            assign in_ready   = adv0;
            assign sub_v      = s0_v_q;
            assign sub_mode   = s0_mode_q;
            assign sub_data   = s0_data_q;
            assign stage_busy = s0_v_q;
        end else begin : g_pipe1
            assign in_ready   = adv_last;
            assign sub_v      = in_valid;
            assign sub_mode   = in_mode;
            assign sub_data   = in_data;
            assign stage_busy = 1'b0;
        end
    endgenerate

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            aes_sbox_lane u_lane (
                .inv_i  (sub_mode),
                .data_i (sub_data[8*i +: 8]),
                .data_o (sub_res[8*i +: 8])
            );
        end
    endgenerate

    always_comb begin
        out_v_d    = out_v_q;
        out_mode_d = out_mode_q;
        out_data_d = out_data_q;
        if (adv_last) begin
            out_v_d = sub_v;
            if (sub_v) begin
                out_mode_d = sub_mode;
                out_data_d = sub_res;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_v_q    <= 1'b0;
            out_mode_q <= 1'b0;
            out_data_q <= '0;
        end else begin
            out_v_q    <= out_v_d;
            out_mode_q <= out_mode_d;
            out_data_q <= out_data_d;
        end
    end

    assign out_valid = out_v_q;
    assign out_mode  = out_mode_q;
    assign out_data  = out_data_q;
    assign busy      = out_v_q || stage_busy;

endmodule

// File: tb/tb_aes_sbox_array.sv
// tb/tb_aes_sbox_array.sv - scoreboard bench for aes_sbox_array, PIPE=1 and PIPE=2 side by side
// Index 0 is the PIPE=1 instance, index 1 the PIPE=2 instance; both see the same word list.

module tb_aes_sbox_array;

    typedef struct packed {
        logic        mode;
        logic [31:0] din;
        logic [31:0] dexp;
        logic        chk;
        logic        use_cap;
        logic        lat;
    } stim_t;

    typedef struct packed {
        stim_t       s;
        logic [31:0] acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        out_ready;
    logic        in_valid [2];
    logic        in_ready [2];
    logic        in_mode  [2];
    logic [31:0] in_data  [2];
    logic        out_valid[2];
    logic        out_mode [2];
    logic [31:0] out_data [2];
    logic        busy     [2];

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    stim_t       stim_q[$];
    exp_t        exp_q0[$];
    exp_t        exp_q1[$];
    logic [31:0] cap[2][256];
    bit          seen[256];
    logic        gap_watch = 1'b0;
    int          last_pop[2];
    int          bubbles[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_sbox_array #(.LANES(4), .PIPE(1)) u_dut_p1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_mode(in_mode[0]), .in_data(in_data[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready), .out_mode(out_mode[0]), .out_data(out_data[0]), .busy(busy[0])
    );

    aes_sbox_array #(.LANES(4), .PIPE(2)) u_dut_p2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_mode(in_mode[1]), .in_data(in_data[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready), .out_mode(out_mode[1]), .out_data(out_data[1]), .busy(busy[1])
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic stim_t mk(input logic mode, input logic [31:0] din, input logic [31:0] dexp,
                                 input logic chk, input logic use_cap, input logic lat);
        stim_t s;
        s.mode = mode; s.din = din; s.dexp = dexp; s.chk = chk; s.use_cap = use_cap; s.lat = lat;
        return s;
    endfunction

    task automatic run(input int k);
        foreach (stim_q[i]) begin
            stim_t s;
            exp_t  e;
            int    t;
            s = stim_q[i];
            if (s.use_cap) s.din = cap[k][s.dexp[7:0]];
            @(negedge clk);
            in_mode[k]  = s.mode;
            in_data[k]  = s.din;
            in_valid[k] = 1'b1;
            #1;
            t = 0;
            while (!in_ready[k] && t < 200) begin
                @(negedge clk);
                #1;
                t++;
            end
            if (t >= 200) begin
                n_chk++;
                n_err++;
                $display("FAIL accept_timeout dut%0d: in_ready stayed 0 for %0d cycles, required 1", k, t);
                break;
            end
            e.s   = s;
            e.acc = cyc;
            if (k == 0) exp_q0.push_back(e);
            else        exp_q1.push_back(e);
        end
        @(negedge clk);
        in_valid[k] = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("drain_p1", exp_q0.size(), 0);
        check("drain_p2", exp_q1.size(), 0);
    endtask

    task automatic play();
        fork
            run(0);
            run(1);
        join
        drain();
    endtask

    task automatic monitor(input int k);
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (out_valid[k] && out_ready) begin
                if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_out dut%0d: got %08h with no word outstanding", k, out_data[k]);
                end else begin
                    e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    check($sformatf("out_mode dut%0d", k), out_mode[k], e.s.mode);
                    if (e.s.chk) check($sformatf("out_data dut%0d in=%08h", k, e.s.din), out_data[k], e.s.dexp);
                    else         cap[k][e.s.din[7:0]] = out_data[k];
                    if (e.s.lat) check($sformatf("latency dut%0d", k), cyc - int'(e.acc), k + 1);
                    if (gap_watch) begin
                        if (last_pop[k] >= 0 && cyc != last_pop[k] + 1) bubbles[k]++;
                        last_pop[k] = cyc;
                    end
                end
            end
        end
    endtask

    initial fork
        monitor(0);
        monitor(1);
    join

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [31:0] V_A = 32'h005301FF, R_A = 32'h63ED7C16;
    localparam logic [31:0] V_B = 32'h10118000, R_B = 32'hCA82CD63;
    localparam logic [31:0] V_C = 32'h006DC164, R_C = 32'h52B3DD8C;

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid[k] = 1'b0; in_mode[k] = 1'b0; in_data[k] = '0;
            last_pop[k] = -1; bubbles[k] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #3;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst out_valid dut%0d", k), out_valid[k], 0);
            check($sformatf("rst out_data dut%0d", k), out_data[k], 0);
            check($sformatf("rst out_mode dut%0d", k), out_mode[k], 0);
            check($sformatf("rst busy dut%0d", k), busy[k], 0);
            check($sformatf("rst in_ready dut%0d", k), in_ready[k], 1);
        end

        // Directed forward and inverse words with known results.
        @(negedge clk);
        out_ready = 1'b1;
        stim_q.delete();
        stim_q.push_back(mk(1'b0, V_A, R_A, 1'b1, 1'b0, 1'b1));
        repeat (3) @(negedge clk);
        play();
        stim_q.delete();
        stim_q.push_back(mk(1'b1, R_A, V_A, 1'b1, 1'b0, 1'b1));
        stim_q.push_back(mk(1'b1, V_C, R_C, 1'b1, 1'b0, 1'b1));
        stim_q.push_back(mk(1'b0, V_B, R_B, 1'b1, 1'b0, 1'b1));
        stim_q.push_back(mk(1'b1, R_B, V_B, 1'b1, 1'b0, 1'b1));
        play();

        // Exhaustive forward sweep, lane l sees x+64*l, then inverse round trip.
        stim_q.delete();
        for (int x = 0; x < 256; x++)
            stim_q.push_back(mk(1'b0, {8'(x + 192), 8'(x + 128), 8'(x + 64), 8'(x)}, '0, 1'b0, 1'b0, 1'b0));
        play();
        for (int k = 0; k < 2; k++) begin
            int bad;
            for (int l = 0; l < 4; l++) begin
                int cnt;
                cnt = 0;
                for (int v = 0; v < 256; v++) seen[v] = 1'b0;
                for (int x = 0; x < 256; x++) seen[cap[k][x][8*l +: 8]] = 1'b1;
                for (int v = 0; v < 256; v++) if (seen[v]) cnt++;
                check($sformatf("fwd permutation dut%0d lane%0d", k, l), cnt, 256);
            end
            bad = 0;
            for (int x = 0; x < 256; x++)
                for (int l = 1; l < 4; l++)
                    if (cap[k][x][8*l +: 8] !== cap[k][(x + 64*l) & 255][7:0]) bad++;
            check($sformatf("lane agreement dut%0d", k), bad, 0);
        end
        stim_q.delete();
        for (int x = 0; x < 256; x++)
            stim_q.push_back(mk(1'b1, '0, {8'(x + 192), 8'(x + 128), 8'(x + 64), 8'(x)}, 1'b1, 1'b1, 1'b0));
        play();

        // Mode alternating every word at full rate.
        stim_q.delete();
        for (int i = 0; i < 4; i++) begin
            stim_q.push_back(mk(1'b0, V_A, R_A, 1'b1, 1'b0, 1'b1));
            stim_q.push_back(mk(1'b1, V_C, R_C, 1'b1, 1'b0, 1'b1));
        end
        last_pop[0] = -1; last_pop[1] = -1; bubbles[0] = 0; bubbles[1] = 0;
        gap_watch = 1'b1;
        play();
        gap_watch = 1'b0;
        check("alt bubbles dut0", bubbles[0], 0);
        check("alt bubbles dut1", bubbles[1], 0);

        // Ten words with a five-cycle output stall in the middle.
        stim_q.delete();
        for (int i = 0; i < 10; i++) begin
            case (i % 3)
                0:       stim_q.push_back(mk(1'b0, V_A, R_A, 1'b1, 1'b0, 1'b0));
                1:       stim_q.push_back(mk(1'b0, V_B, R_B, 1'b1, 1'b0, 1'b0));
                default: stim_q.push_back(mk(1'b1, R_B, V_B, 1'b1, 1'b0, 1'b0));
            endcase
        end
        bubbles[0] = 0; bubbles[1] = 0;
        fork
            play();
            begin
                repeat (4) @(negedge clk);
                out_ready = 1'b0;
                repeat (4) @(negedge clk);
                #3;
                for (int k = 0; k < 2; k++) begin
                    check($sformatf("stall in_ready dut%0d", k), in_ready[k], 0);
                    check($sformatf("stall out_valid dut%0d", k), out_valid[k], 1);
                    check($sformatf("stall busy dut%0d", k), busy[k], 1);
                end
                @(negedge clk);
                last_pop[0] = -1; last_pop[1] = -1;
                gap_watch = 1'b1;
                out_ready = 1'b1;
            end
        join
        gap_watch = 1'b0;
        check("release bubbles dut0", bubbles[0], 0);
        check("release bubbles dut1", bubbles[1], 0);

        // Reset with words in flight and the output stalled.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid[0] = 1'b1; in_valid[1] = 1'b1;
        in_mode[0] = 1'b0; in_mode[1] = 1'b0;
        in_data[0] = V_A; in_data[1] = V_A;
        @(negedge clk);
        in_valid[0] = 1'b0;
        in_data[1] = V_B;
        @(negedge clk);
        in_valid[1] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #3;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("midrst out_valid dut%0d", k), out_valid[k], 0);
            check($sformatf("midrst busy dut%0d", k), busy[k], 0);
            check($sformatf("midrst out_data dut%0d", k), out_data[k], 0);
            check($sformatf("midrst in_ready dut%0d", k), in_ready[k], 1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        stim_q.delete();
        stim_q.push_back(mk(1'b1, V_C, R_C, 1'b1, 1'b0, 1'b1));
        play();

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
